// File: rtl/ps2_kbd_fifo.sv
// PS/2 keyboard receiver: synchronizes the raw PS/2 lines, deframes 11-bit frames
// with odd-parity/stop validation, and queues accepted bytes in a show-ahead FIFO.
module ps2_kbd_fifo #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       read_enable,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    CHECK
  } state_t;

  state_t        state, state_next;
  logic          clk_s1, clk_s2, clk_d;
  logic          dat_s1, dat_s2;
  logic          fall;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic [10:0]   frame;
  logic          frame_ok;
  logic          push;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wptr, rptr;
  logic          empty, full, pop, wr_en, drop;

  // clk_d holds the previous synchronized PS/2 clock for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_d  <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      clk_d  <= clk_s2;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  assign fall     = clk_d & ~clk_s2;
  assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign frame_ok = (^frame[9:1]) & frame[10];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    push       = 1'b0;
    case (state)
      IDLE:  if (fall && !dat_s2) state_next = RECV;
      RECV: begin
        if (fall) begin
          if (bit_cnt == 4'd10) state_next = CHECK;
        end else if (tmo_hit) begin
          state_next = IDLE;
        end
      end
      CHECK: begin
        push       = frame_ok;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
      tmo_cnt <= '0;
      frame   <= '0;
    end else begin
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (fall && !dat_s2) begin
            frame[0] <= 1'b0;
            bit_cnt  <= 4'd1;
          end
        end
        RECV: begin
          if (fall) begin
            frame[bit_cnt] <= dat_s2;
            tmo_cnt        <= '0;
            bit_cnt        <= (bit_cnt == 4'd10) ? 4'd0 : bit_cnt + 4'd1;
          end else if (tmo_hit) begin
            tmo_cnt <= '0;
            bit_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: begin
          tmo_cnt <= '0;
          bit_cnt <= '0;
        end
      endcase
    end
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign pop   = read_enable & ~empty;
  // a pop frees the slot in the same cycle, so a full FIFO still accepts the push
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= frame[8:1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
      if (drop)     overflow <= 1'b1;
      else if (pop) overflow <= 1'b0;
    end
  end

  assign ready = ~empty;
  assign data  = empty ? '0 : mem[rptr[AW-1:0]];

endmodule
